lift: RTL and testbench
=======================

# lift

Single-car elevator controller for an 8-floor building (floors 0–7). It accepts one hall call at a time and moves the car to the caller's floor. It holds the door there, then takes the in-car floor selection and carries the passenger to it. It is a standalone top-level control block: inputs come from the hall/car button logic, and the outputs report car position and busy status to indicators.

## Interface
- FLOOR_TICKS, 4: clock cycles to travel one floor (≥1).
- DOOR_TICKS, 4: clock cycles the door dwell lasts at a stop (≥1).
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-high (despite the name); while high, all state is forced to reset values.
- butt_el  in  3  in-car destination floor selection, binary 0–7.
- butt_up_down  in  1  hall call request, level-sensitive, active-high.
- pass_f  in  3  floor where the hall call was made, binary 0–7.
- elev_f_o  out  3  current car floor, registered.
- busy_o  out  1  1 = serving a call, 0 = idle and accepting calls; registered.

## Operation
- Internal state: FSM state, target floor register (3 b), step/dwell timer (wide enough for max(FLOOR_TICKS, DOOR_TICKS)-1).
- States: IDLE, GO_PICKUP, DOOR_PICKUP, GO_DEST, DOOR_DEST.
- IDLE, butt_up_down=1 sampled:
  - latch pass_f as target; set busy_o=1; clear the timer.
  - If pass_f ≠ elev_f_o, go to GO_PICKUP. Otherwise go straight to DOOR_PICKUP.
- IDLE, butt_up_down=0: stay; busy_o=0.
- GO_PICKUP / GO_DEST:
  - Timer increments each cycle.
  - When the timer equals FLOOR_TICKS-1, elev_f_o steps by +1 if target > elev_f_o, or by -1 otherwise, and the timer clears.
  - If the new floor equals target, the state moves on the same edge to DOOR_PICKUP or DOOR_DEST respectively.
- DOOR_PICKUP: timer increments. On the edge where it equals DOOR_TICKS-1:
  - sample butt_el into target and clear the timer;
  - if butt_el ≠ elev_f_o, go to GO_DEST; else go to IDLE with busy_o=0.
- DOOR_DEST: on the edge where the timer equals DOOR_TICKS-1, go to IDLE with busy_o=0.
- Calls are ignored while busy_o=1. pass_f and butt_up_down changes are not queued.
- butt_el is ignored everywhere except at the DOOR_PICKUP exit edge.
- No wrap-around: target is always 0–7, so the floor never steps below 0 or above 7.
- An unused/illegal FSM encoding recovers to IDLE with busy_o=0 and keeps the current floor.

## Timing
- Reset values: elev_f_o=0, busy_o=0, state IDLE, target=0, timer=0.
- Reset asserted mid-trip aborts immediately; the car position returns to 0.
- Call acceptance: busy_o rises on the edge that samples butt_up_down=1 (edge A).
- Travel latency: the first floor change occurs at edge A+FLOOR_TICKS; each further floor takes FLOOR_TICKS cycles.
- Door dwell: exactly DOOR_TICKS cycles after the arrival edge.
- busy_o falls on the DOOR_DEST exit edge. If butt_up_down is still high in the next IDLE cycle, a new call is accepted one cycle after busy_o falls.
- Same-floor call: DOOR_PICKUP is entered at edge A with no travel.

## Test plan
All scenarios use default parameters.
- **Reset:** assert rst_n=1 for 3 cycles with inputs X.
  - elev_f_o=0 and busy_o=0 throughout, and after release.
- **Call from floor 3, destination 7:** from floor 0, pass_f=3, butt_up_down=1, butt_el=7, accepted at edge A.
  - busy_o=1 at A; elev_f_o=1,2,3 at A+4, A+8, A+12.
  - Dest latched at A+16; elev_f_o=4,5,6,7 at A+20, A+24, A+28, A+32.
  - busy_o=0 at A+36.
- **Downward trip:** from floor 7, pass_f=2, butt_el=5, butt_up_down held high.
  - Car descends 7→2 at 4-cycle steps, dwells 4 cycles, climbs 2→5, then goes idle.
  - With butt_up_down still high, the call is re-accepted.
- **Ignored calls while busy:** change pass_f to 6 and pulse butt_up_down mid-trip.
  - Trip is unaffected; no extra stop at floor 6.
- **Same-floor cases:** car at floor 3, pass_f=3.
  - Door dwell starts at the accept edge.
  - With butt_el=3, busy_o=0 4 cycles after acceptance and elev_f_o stays 3.
- **Reset mid-trip:** assert rst_n during GO_DEST.
  - Outputs go to 0 asynchronously; after release, a new call is served from floor 0.

Source files
------------

// File: rtl/lift.sv
// -----------------------------------------------------------------------------
// lift -- single-car elevator controller for an 8-floor building (floors 0-7).
//
// The car serves one hall call at a time:
//   1. In IDLE a hall call (butt_up_down) latches the caller's floor (pass_f).
//   2. The car travels to that floor, one floor every FLOOR_TICKS cycles.
//   3. The door dwells for DOOR_TICKS cycles.
//   4. At the end of the dwell the in-car selection (butt_el) is sampled.
//   5. The car carries the passenger there, dwells again and returns to IDLE.
// Calls arriving while busy are ignored; nothing is queued.
//
// Parameters
//   FLOOR_TICKS  clock cycles to travel one floor (>= 1)
//   DOOR_TICKS   clock cycles of door dwell at a stop (>= 1)
//
// Ports
//   clk           in   system clock, rising-edge active
//   rst_n         in   asynchronous reset, active-HIGH despite the name
//   butt_el       in   [2:0] in-car destination floor, sampled only at the
//                      end of the pickup dwell
//   butt_up_down  in   hall call request, level-sensitive, active-high
//   pass_f        in   [2:0] floor the hall call was made from
//   elev_f_o      out  [2:0] current car floor, registered
//   busy_o        out  1 while serving a call, 0 when idle; registered
// -----------------------------------------------------------------------------
module lift #(
    parameter int unsigned FLOOR_TICKS = 4,
    parameter int unsigned DOOR_TICKS  = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] butt_el,
    input  logic       butt_up_down,
    input  logic [2:0] pass_f,
    output logic [2:0] elev_f_o,
    output logic       busy_o
);

    // One timer serves both travel and dwell, so it must reach the larger
    // terminal count. Keep at least one bit when both counts are 1.
    localparam int unsigned MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int unsigned TW        = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);

    typedef enum logic [2:0] {
        StIdle       = 3'd0,
        StGoPickup   = 3'd1,
        StDoorPickup = 3'd2,
        StGoDest     = 3'd3,
        StDoorDest   = 3'd4
    } state_e;

    state_e        state;
    logic [2:0]    target;
    logic [TW-1:0] timer;

    // Floor the car reaches when the current travel step completes. If the
    // car is somehow already at the target it stays put instead of stepping
    // away, which keeps the floor inside 0-7 under every condition.
    logic [2:0] step_floor;
    logic       step_done;
    logic       floor_tick;
    logic       door_tick;

    always_comb begin
        step_floor = elev_f_o;
        if (target > elev_f_o) begin
            step_floor = elev_f_o + 3'd1;
        end else if (target < elev_f_o) begin
            step_floor = elev_f_o - 3'd1;
        end
    end

    assign step_done  = (step_floor == target);
    assign floor_tick = (timer == FLOOR_LAST);
    assign door_tick  = (timer == DOOR_LAST);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state    <= StIdle;
            target   <= 3'd0;
            timer    <= '0;
            elev_f_o <= 3'd0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (butt_up_down) begin
                        target <= pass_f;
                        busy_o <= 1'b1;
                        timer  <= '0;
                        // A call from the car's own floor opens the door at once.
                        if (pass_f != elev_f_o) begin
                            state <= StGoPickup;
                        end else begin
                            state <= StDoorPickup;
                        end
                    end else begin
                        busy_o <= 1'b0;
                    end
                end

                StGoPickup, StGoDest: begin
                    if (floor_tick) begin
                        timer    <= '0;
                        elev_f_o <= step_floor;
                        // Arrival switches to the dwell on the same edge.
                        if (step_done) begin
                            if (state == StGoPickup) begin
                                state <= StDoorPickup;
                            end else begin
                                state <= StDoorDest;
                            end
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                StDoorPickup: begin
                    if (door_tick) begin
                        // The only point at which the in-car selection is read.
                        target <= butt_el;
                        timer  <= '0;
                        if (butt_el != elev_f_o) begin
                            state <= StGoDest;
                        end else begin
                            state  <= StIdle;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                StDoorDest: begin
                    if (door_tick) begin
                        timer  <= '0;
                        state  <= StIdle;
                        busy_o <= 1'b0;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end

                // Unused encodings: drop the trip, keep the car where it is.
                default: begin
                    state  <= StIdle;
                    busy_o <= 1'b0;
                    timer  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lift.sv
// -----------------------------------------------------------------------------
// tb_lift -- self-checking bench for lift.
// A trip-level reference model expands each accepted call into the expected
// per-edge sequence of (floor, busy) using plain arithmetic on floor distance
// and tick counts. The destination leg is appended when the pickup dwell
// ends, using the butt_el value presented at that edge.
// -----------------------------------------------------------------------------
module tb_lift;

    localparam int FT = 4;
    localparam int DT = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] butt_el;
    logic       butt_up_down;
    logic [2:0] pass_f;
    logic [2:0] elev_f_o;
    logic       busy_o;

    always #5 clk = ~clk;

    lift #(
        .FLOOR_TICKS (FT),
        .DOOR_TICKS  (DT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .butt_el      (butt_el),
        .butt_up_down (butt_up_down),
        .pass_f       (pass_f),
        .elev_f_o     (elev_f_o),
        .busy_o       (busy_o)
    );

    // One entry per future clock edge: the expected outputs after that edge.
    typedef struct {
        int floor;
        bit busy;
        bit decide;  // end of pickup dwell: destination is read here
    } step_t;

    step_t plan[$];
    int    exp_floor;
    int    exp_busy;
    int    pick_floor;
    int    n_tests;
    int    n_fail;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Travel from one floor to another: the floor changes every FT edges.
    task automatic add_leg(input int from, input int to);
        int dir;
        int n;
        dir = (to > from) ? 1 : -1;
        n   = (to - from) * dir * FT;
        for (int j = 1; j <= n; j++) begin
            plan.push_back('{floor: from + dir * (j / FT), busy: 1'b1, decide: 1'b0});
        end
    endtask

    // Door dwell: DT edges at a floor; the last one ends the stop.
    task automatic add_dwell(input int fl, input bit decide, input bit last_busy);
        for (int j = 1; j <= DT; j++) begin
            plan.push_back('{floor: fl, busy: (j == DT) ? last_busy : 1'b1,
                             decide: decide && (j == DT)});
        end
    endtask

    // Expected outputs after the coming edge, given the inputs now driven.
    task automatic predict();
        step_t s;
        if (plan.size() == 0) begin
            if (butt_up_down) begin
                pick_floor = int'(pass_f);
                exp_busy   = 1;
                add_leg(exp_floor, pick_floor);
                add_dwell(pick_floor, 1'b1, 1'b1);
            end else begin
                exp_busy = 0;
            end
        end else begin
            s         = plan.pop_front();
            exp_floor = s.floor;
            exp_busy  = s.busy;
            if (s.decide) begin
                if (int'(butt_el) == pick_floor) begin
                    exp_busy = 0;
                end else begin
                    add_leg(pick_floor, int'(butt_el));
                    add_dwell(int'(butt_el), 1'b0, 1'b0);
                end
            end
        end
    endtask

    task automatic cycle(input logic ud, input logic [2:0] pf, input logic [2:0] be);
        butt_up_down = ud;
        pass_f       = pf;
        butt_el      = be;
        predict();
        @(posedge clk);
        #1;
        check_eq("floor", int'(elev_f_o), exp_floor);
        check_eq("busy", int'(busy_o), exp_busy);
    endtask

    task automatic run(input int n, input logic ud, input logic [2:0] pf, input logic [2:0] be);
        for (int i = 0; i < n; i++) begin
            cycle(ud, pf, be);
        end
    endtask

    task automatic model_clear();
        plan.delete();
        exp_floor = 0;
        exp_busy  = 0;
    endtask

    // Reset held for n edges with arbitrary inputs; outputs must stay 0.
    task automatic do_reset(input int n);
        rst_n = 1'b1;
        for (int i = 0; i < n; i++) begin
            butt_up_down = 1'($urandom);
            pass_f       = 3'($urandom);
            butt_el      = 3'($urandom);
            @(posedge clk);
            #1;
            check_eq("rst_floor", int'(elev_f_o), 0);
            check_eq("rst_busy", int'(busy_o), 0);
        end
        rst_n = 1'b0;
        model_clear();
    endtask

    // Reset asserted between edges: outputs must clear without a clock edge.
    task automatic mid_reset();
        #1;
        rst_n = 1'b1;
        #1;
        check_eq("async_floor", int'(elev_f_o), 0);
        check_eq("async_busy", int'(busy_o), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        rst_n        = 1'b1;
        butt_up_down = 1'b0;
        pass_f       = 3'd0;
        butt_el      = 3'd0;
        model_clear();

        do_reset(3);
        run(2, 1'b0, 3'd5, 3'd6);

        // Call from floor 3 to floor 7, starting at floor 0.
        cycle(1'b1, 3'd3, 3'd7);
        run(40, 1'b0, 3'd0, 3'd7);
        check_eq("trip1_floor", int'(elev_f_o), 7);

        // Downward pickup 7->2, up to 5, call held high so it is re-accepted.
        run(50, 1'b1, 3'd2, 3'd5);
        // Calls while busy are ignored: move pass_f to 6 and pulse the call.
        run(10, 1'b0, 3'd6, 3'd5);
        run(3, 1'b1, 3'd6, 3'd5);
        run(40, 1'b0, 3'd6, 3'd5);

        // Bring the car to floor 3, then same-floor call with same-floor dest.
        cycle(1'b1, 3'd3, 3'd3);
        run(30, 1'b0, 3'd3, 3'd3);
        cycle(1'b1, 3'd3, 3'd3);
        run(DT, 1'b0, 3'd3, 3'd3);
        check_eq("same_floor", int'(elev_f_o), 3);
        // Same-floor pickup, different destination.
        cycle(1'b1, 3'd3, 3'd0);
        run(30, 1'b0, 3'd3, 3'd0);

        // Reset during the destination leg, then a fresh call from floor 0.
        cycle(1'b1, 3'd5, 3'd1);
        run(30, 1'b0, 3'd5, 3'd1);
        mid_reset();
        cycle(1'b1, 3'd2, 3'd4);
        run(40, 1'b0, 3'd2, 3'd4);

        // Randomized traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            if (exp_busy != 0 && $urandom_range(0, 299) == 0) begin
                mid_reset();
            end else begin
                cycle(($urandom_range(0, 3) == 0), 3'($urandom), 3'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
